// File: rtl/mem_pkg.sv
// Shared memory-handshake definitions: responder FSM states, transfer
// direction encodings used by the core's memory-mode logic, default widths.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } mem_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int DATA_WIDTH         = 16;
    localparam int BUS_ADDR_WIDTH     = 16;
    localparam int CNT_WIDTH          = 4;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_LATENCY    = 2;
    localparam int DEFAULT_ROM_WORDS  = 256;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port. The read
// register only loads on a read, so it holds the last value read and the
// array itself stays free of reset logic for block-RAM inference.
import mem_pkg::*;

module mem_array #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read data, cleared by reset, updated only on reads.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_target.sv
// Memory handshake responder: accepts one request at a time from the core,
// waits LATENCY cycles, then performs the RAM access and signals completion.
// Optional build macro MEM_TARGET_ROM_PROTECT_EN drops writes to the
// lowest ROM_WORDS words and pulses O_wr_fault instead.
import mem_pkg::*;

module mem_target #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int ROM_WORDS  = DEFAULT_ROM_WORDS
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_exec,
    input  logic        I_write,
    input  logic [15:0] I_addr,
    input  logic [15:0] I_data,
    output logic        O_ready,
    output logic [15:0] O_data,
    output logic        O_data_ready,
    output logic        O_wr_fault
);

    mem_state_t            state;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  wr_blocked;
    logic                  ram_we;
    logic                  ram_re;

    // Bus address bits above the RAM depth are ignored, giving address wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^I_addr[BUS_ADDR_WIDTH-1:ADDR_WIDTH];

`ifdef MEM_TARGET_ROM_PROTECT_EN
    // Protected region check on the latched address.
    assign wr_blocked = (32'(req_addr) < ROM_WORDS);
`else
    logic unused_rom_cfg;
    assign unused_rom_cfg = (ROM_WORDS > 0);
    assign wr_blocked     = 1'b0;
`endif

    // RAM is only touched in ACCESS; reset in that cycle aborts the access.
    assign ram_we = I_reset && (state == ACCESS) && (req_write == MEM_WRITE) && !wr_blocked;
    assign ram_re = I_reset && (state == ACCESS) && (req_write == MEM_READ);

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk   (I_clk),
        .rst_b (I_reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (req_addr),
        .wdata (req_data),
        .rdata (O_data)
    );

    // Handshake FSM with latency down-counter and registered strobes.
    always_ff @(posedge I_clk) begin
        if (!I_reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            req_addr     <= '0;
            req_write    <= MEM_READ;
            req_data     <= '0;
            O_ready      <= 1'b1;
            O_data_ready <= 1'b0;
            O_wr_fault   <= 1'b0;
        end else begin
            O_data_ready <= 1'b0;
            O_wr_fault   <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_exec) begin
                        req_addr  <= I_addr[ADDR_WIDTH-1:0];
                        req_write <= I_write;
                        req_data  <= I_data;
                        wait_cnt  <= CNT_WIDTH'(LATENCY);
                        O_ready   <= 1'b0;
                        state     <= (LATENCY > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_WIDTH'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    O_ready      <= 1'b1;
                    O_data_ready <= (req_write == MEM_READ);
                    O_wr_fault   <= (req_write == MEM_WRITE) && wr_blocked;
                    state        <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    O_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: instance 0 with LATENCY=2, instance 1 with LATENCY=0.
// Directed table plus reset/protection sequences, then random traffic
// checked against an array model of memory contents.
module tb_mem_target;

`ifdef MEM_TARGET_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk;
    logic        rst   [2];
    logic        exec  [2];
    logic        write [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic [15:0] odata [2];
    logic        dr    [2];
    logic        fault [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cyc [2];

    logic [15:0] ref_mem   [2][1024];
    logic [15:0] ref_odata [2];
    int          wlist0 [$];
    int          wlist1 [$];

    mem_target #(.ADDR_WIDTH(10), .LATENCY(2), .ROM_WORDS(256)) u_dut0 (
        .I_clk(clk), .I_reset(rst[0]), .I_exec(exec[0]), .I_write(write[0]),
        .I_addr(addr[0]), .I_data(wdata[0]), .O_ready(ready[0]), .O_data(odata[0]),
        .O_data_ready(dr[0]), .O_wr_fault(fault[0])
    );

    mem_target #(.ADDR_WIDTH(10), .LATENCY(0), .ROM_WORDS(256)) u_dut1 (
        .I_clk(clk), .I_reset(rst[1]), .I_exec(exec[1]), .I_write(write[1]),
        .I_addr(addr[1]), .I_data(wdata[1]), .O_ready(ready[1]), .O_data(odata[1]),
        .O_data_ready(dr[1]), .O_wr_fault(fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Issue one request at the current negedge and follow it to its response.
    task automatic req(input int d, input bit wr, input logic [15:0] a,
                       input logic [15:0] wd, input bit junk, input bit do_chk,
                       input logic [15:0] exp, input bit exp_fault,
                       output logic [15:0] got);
        chk("ready_before_req", ready[d], 1);
        exec[d] = 1'b1; write[d] = wr; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        for (int k = 0; k <= lat(d); k++) begin
            chk("busy_ready", ready[d], 0);
            chk("busy_data_ready", dr[d], 0);
            chk("busy_wr_fault", fault[d], 0);
            if (junk) begin
                exec[d] = 1'b1; write[d] = ~wr; addr[d] = a ^ 16'h0155; wdata[d] = ~wd;
            end else begin
                exec[d] = 1'b0;
            end
            @(negedge clk);
        end
        exec[d] = 1'b0;
        chk("resp_ready", ready[d], 1);
        chk("resp_data_ready", dr[d], {15'd0, ~wr});
        chk("resp_wr_fault", fault[d], {15'd0, exp_fault});
        if (do_chk) chk("resp_data", odata[d], exp);
        got = odata[d];
        resp_cyc[d] = cyc;
    endtask

    task automatic idle_check(input int d);
        @(negedge clk);
        chk("idle_ready", ready[d], 1);
        chk("idle_data_ready", dr[d], 0);
        chk("idle_wr_fault", fault[d], 0);
    endtask

    // Accept a write, then reset in the following cycle before it completes.
    task automatic reset_abort(input int d, input logic [15:0] a, input logic [15:0] wd);
        exec[d] = 1'b1; write[d] = 1'b1; addr[d] = a; wdata[d] = wd;
        @(negedge clk);
        exec[d] = 1'b0;
        rst[d]  = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready[d], 1);
        chk("abort_data", odata[d], 16'h0000);
        chk("abort_data_ready", dr[d], 0);
        chk("abort_wr_fault", fault[d], 0);
        rst[d] = 1'b1;
        idle_check(d);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] wd;
        bit          junk;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [15:0] g;
        int r1;

        tbl[0] = '{1'b1, 16'h0300, 16'hBEEF, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'h0300, 16'h0000, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b1, 16'h0005, 16'hAAAA, 1'b0, 16'hBEEF};
        tbl[3] = '{1'b0, 16'hFC05, 16'h0000, 1'b0, 16'hAAAA};
        tbl[4] = '{1'b0, 16'h0300, 16'h0000, 1'b1, 16'hBEEF};
        tbl[5] = '{1'b1, 16'h0100, 16'h5555, 1'b1, 16'hBEEF};
        tbl[6] = '{1'b0, 16'h0100, 16'h0000, 1'b0, 16'h5555};
        tbl[7] = '{1'b1, 16'h03FF, 16'h7777, 1'b0, 16'h5555};
        tbl[8] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h7777};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; exec[d] = 1'b0; write[d] = 1'b0;
            addr[d] = 16'h0; wdata[d] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", ready[d], 1);
            chk("reset_data", odata[d], 16'h0000);
            chk("reset_data_ready", dr[d], 0);
            chk("reset_wr_fault", fault[d], 0);
            rst[d] = 1'b1;
        end
        @(negedge clk);

        // Directed table on the LATENCY=2 instance.
        for (int i = 0; i < 9; i++) begin
            req(0, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].junk, 1'b1, tbl[i].exp, 1'b0, g);
        end
        idle_check(0);

        // Reset during WAIT of a write must leave the old contents.
        req(0, 1'b1, 16'h0020, 16'h2222, 1'b0, 1'b1, 16'h7777, 1'b0, g);
        req(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0, g);
        idle_check(0);
        reset_abort(0, 16'h0020, 16'h1111);
        req(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0, g);

        // Protected region handling (fault only in the protected build).
        req(0, 1'b1, 16'h0080, 16'h9999, 1'b0, 1'b1, 16'h2222, PROT, g);
        req(0, 1'b0, 16'h0080, 16'h0000, 1'b0, !PROT, 16'h9999, 1'b0, g);
        if (PROT) chk("rom_kept_old", {15'd0, g !== 16'h9999}, 16'h0001);
        req(0, 1'b1, 16'h0100, 16'h6666, 1'b0, !PROT, 16'h9999, 1'b0, g);
        req(0, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h6666, 1'b0, g);
        idle_check(0);

        // LATENCY=0 instance: back-to-back reads two cycles apart.
        req(1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, g);
        req(1, 1'b1, 16'h0011, 16'h5678, 1'b0, 1'b1, 16'h0000, 1'b0, g);
        req(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, g);
        r1 = resp_cyc[1];
        req(1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b1, 16'h5678, 1'b0, g);
        chk("b2b_spacing", 16'(resp_cyc[1] - r1), 16'd2);
        idle_check(1);
        req(1, 1'b1, 16'h0020, 16'h2222, 1'b0, 1'b1, 16'h5678, 1'b0, g);
        idle_check(1);
        reset_abort(1, 16'h0020, 16'h1111);
        req(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0, g);
        idle_check(1);

        // Random traffic above the protected region against the array model.
        ref_odata[0] = 16'h6666;
        ref_odata[1] = 16'h2222;
        for (int n = 0; n < 60; n++) begin
            int d, idx;
            bit wr, junk;
            logic [15:0] a, wd, e;
            d    = int'($urandom_range(0, 1));
            junk = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if ((d == 0 && wlist0.size() == 0) || (d == 1 && wlist1.size() == 0)) wr = 1'b1;
            if (wr) begin
                idx = int'($urandom_range(256, 1023));
                a   = 16'(($urandom_range(0, 63) << 10) | idx);
                wd  = 16'($urandom);
                e   = ref_odata[d];
                ref_mem[d][idx] = wd;
                if (d == 0) wlist0.push_back(idx); else wlist1.push_back(idx);
            end else begin
                if (d == 0) idx = wlist0[$urandom_range(0, wlist0.size() - 1)];
                else        idx = wlist1[$urandom_range(0, wlist1.size() - 1)];
                a  = 16'(($urandom_range(0, 63) << 10) | idx);
                wd = 16'($urandom);
                e  = ref_mem[d][idx];
                ref_odata[d] = e;
            end
            req(d, wr, a, wd, junk, 1'b1, e, 1'b0, g);
            if ($urandom_range(0, 2) == 0) idle_check(d);
        end
        idle_check(0);
        idle_check(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
